ddr_serialiser: RTL and testbench

Parallel-to-DDR serialiser that sits directly upstream of the DDR output cell. It accepts W-bit words over a valid/ready handshake and emits two bits per clock as a rise/fall pair. The outputs connect straight to the cell's `d_rise`/`d_fall`/`e` inputs. Back-to-back words stream with no gap; idle cycles drive a fixed idle level.

---
 rtl/ddr_serialiser_defs.sv | 38 +++
 rtl/ddr_serialiser.sv | 125 ++++++++++++
 tb/tb_ddr_serialiser.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_serialiser_defs.sv
// rtl/ddr_serialiser_defs.sv - shared helpers and derived sizing for ddr_serialiser
//
// Purpose: clog2 plus the functions the serialiser uses to derive its
// localparams (PAIRS = W/2, CNT_W = clog2(W/2+1)) and to validate W.
// Ports: none (package).
package ddr_serialiser_defs;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Number of rise/fall pairs a W-bit word occupies.
  function automatic int pairs_of(input int w);
    return w / 2;
  endfunction

  // Width of the pair counter: must hold 0..W/2.
  function automatic int cnt_width(input int w);
    int r;
    r = clog2(w / 2 + 1);
    return (r < 1) ? 1 : r;
  endfunction

  // W must be even and at least 2 so every word splits into whole pairs.
  function automatic bit w_is_valid(input int w);
    return (w >= 2) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/ddr_serialiser.sv
// rtl/ddr_serialiser.sv - parallel-to-DDR serialiser feeding a DDR output cell
//
// Purpose: accepts W-bit words on a valid/ready handshake and emits them MSB
// first as two bits per clock (d_rise, d_fall). Consecutive words stream with
// no gap; idle cycles drive IDLE_LEVEL on both bits.
// Optional feature: define DDR_SERIALISER_UNDERFLOW_EN to add a sticky
// underflow flag for bursts that end without in_last.
//
// Ports:
//   clk            in   clock (also the DDR cell clock)
//   rst            in   asynchronous active-high reset
//   in_data  [W]   in   word to serialise, MSB sent first
//   in_last        in   final word of a burst (used only with underflow)
//   in_valid       in   word present
//   in_ready       out  word can be accepted this cycle
//   d_rise         out  bit for the rising half-cycle
//   d_fall         out  bit for the falling half-cycle
//   e              out  DDR cell clock enable, 1 from the first edge after reset
//   busy           out  a word is being shifted out
//   underflow_clr  in   clear sticky underflow (optional)
//   underflow      out  sticky underflow flag (optional)
module ddr_serialiser
  import ddr_serialiser_defs::*;
#(
  parameter int   W          = 10,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         d_rise,
  output logic         d_fall,
  output logic         e,
  output logic         busy
`ifdef DDR_SERIALISER_UNDERFLOW_EN
  ,
  input  logic         underflow_clr,
  output logic         underflow
`endif
);

  localparam int PAIRS = pairs_of(W);
  localparam int CNT_W = cnt_width(W);

  if (!w_is_valid(W)) begin : g_bad_w
    $error("ddr_serialiser: W must be even and >= 2");
  end

  logic [W-1:0]     sr;
  logic [W-1:0]     sr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             active_nxt;

  // Ready on the last pair as well as when idle, so the reload lands on the
  // edge that retires the last pair and the stream stays gapless.
  assign in_ready = (cnt == '0) || (cnt == CNT_W'(1));
  assign accept   = in_valid && in_ready;

  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = cnt;
    if (accept) begin
      sr_nxt  = in_data;
      cnt_nxt = CNT_W'(PAIRS);
    end else if (cnt != '0) begin
      sr_nxt  = sr << 2;
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  assign active_nxt = (cnt_nxt != '0);

  // The output bits are flops loaded from next state, so the DDR cell sees
  // clean registered data and a reset forces the idle level at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      cnt    <= '0;
      d_rise <= IDLE_LEVEL;
      d_fall <= IDLE_LEVEL;
      busy   <= 1'b0;
      e      <= 1'b0;
    end else begin
      sr     <= sr_nxt;
      cnt    <= cnt_nxt;
      d_rise <= active_nxt ? sr_nxt[W-1] : IDLE_LEVEL;
      d_fall <= active_nxt ? sr_nxt[W-2] : IDLE_LEVEL;
      busy   <= active_nxt;
      e      <= 1'b1;
    end
  end

`ifdef DDR_SERIALISER_UNDERFLOW_EN
  logic last_r;
  logic underflow_set;

  // Final pair of a non-last word retires with nothing to follow it.
  assign underflow_set = (cnt == CNT_W'(1)) && !accept && !last_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (accept) begin
        last_r <= in_last;
      end
      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

endmodule

// File: tb/tb_ddr_serialiser.sv
// tb/tb_ddr_serialiser.sv - self-checking bench for ddr_serialiser
module tb_ddr_serialiser;

  localparam int   W    = 10;
  localparam logic IDLE = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic         d_rise;
  logic         d_fall;
  logic         e;
  logic         busy;
`ifdef DDR_SERIALISER_UNDERFLOW_EN
  logic         underflow_clr;
  logic         underflow;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ddr_serialiser #(.W(W), .IDLE_LEVEL(IDLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d_rise   (d_rise),
    .d_fall   (d_fall),
    .e        (e),
    .busy     (busy)
`ifdef DDR_SERIALISER_UNDERFLOW_EN
    ,
    .underflow_clr (underflow_clr),
    .underflow     (underflow)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of bits still to appear on the pins, front pair
  // being the one on the outputs now. A word is taken when at most one pair
  // remains; each edge retires the displayed pair and appends accepted bits.
  bit           q[$];
  bit           m_last = 1'b0;
  bit           m_uf   = 1'b0;
  bit           m_e    = 1'b0;
  bit           m_acc  = 1'b0;
  logic [W-1:0] ref_words[$];
  bit           dut_bits[$];
  int           busy_cycles = 0;
  bit           chk_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_last = 1'b0;
      m_uf   = 1'b0;
      m_e    = 1'b0;
      m_acc  = 1'b0;
    end else begin
      bit uf_set;
      m_e    = 1'b1;
      m_acc  = in_valid && (q.size() <= 2);
      uf_set = (q.size() == 2) && !m_acc && !m_last;
      if (q.size() >= 2) begin
        void'(q.pop_front());
        void'(q.pop_front());
      end
      if (m_acc) begin
        for (int b = W - 1; b >= 0; b--) q.push_back(in_data[b]);
        m_last = in_last;
        ref_words.push_back(in_data);
      end
`ifdef DDR_SERIALISER_UNDERFLOW_EN
      if (uf_set) m_uf = 1'b1;
      else if (underflow_clr) m_uf = 1'b0;
`else
      if (uf_set) m_uf = 1'b1;
`endif
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit er;
      bit ef;
      er = (q.size() >= 2) ? q[0] : IDLE;
      ef = (q.size() >= 2) ? q[1] : IDLE;
      chk("d_rise", d_rise, er);
      chk("d_fall", d_fall, ef);
      chk("busy", busy, q.size() != 0);
      chk("in_ready", in_ready, q.size() <= 2);
      chk("e", e, m_e);
`ifdef DDR_SERIALISER_UNDERFLOW_EN
      chk("underflow", underflow, m_uf);
`endif
      if (busy === 1'b1) begin
        dut_bits.push_back(d_rise);
        dut_bits.push_back(d_fall);
        busy_cycles++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    bit [1:0]     pairs1[5];
    bit           rdy1[6];
    int           words;
    int           cycles;

    w1     = 10'b1011001110;
    w2     = 10'b1100100111;
    pairs1 = '{2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
    rdy1   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
`ifdef DDR_SERIALISER_UNDERFLOW_EN
    underflow_clr = 1'b0;
`endif
    @(negedge clk);
    chk("reset d_rise", d_rise, IDLE);
    chk("reset d_fall", d_fall, IDLE);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset e", e, 0);
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("e after reset", e, 1);

    // Single word, valid for one cycle.
    chk("w1 ready at accept", in_ready, rdy1[0]);
    in_valid = 1'b1;
    in_data  = w1;
    in_last  = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    for (int k = 0; k < 5; k++) begin
      chk("w1 pair", {d_rise, d_fall}, pairs1[k]);
      chk("w1 ready", in_ready, rdy1[k+1]);
      cyc();
    end
    chk("w1 idle after", {busy, d_rise, d_fall}, {1'b0, IDLE, IDLE});

    // Two words back to back, no idle cycle between them.
    in_valid = 1'b1;
    in_data  = 10'h3FF;
    in_last  = 1'b0;
    cyc();
    in_data  = 10'h000;
    in_last  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      chk("b2b pair", {d_rise, d_fall}, (k <= 5) ? 2'b11 : 2'b00);
      chk("b2b busy", busy, 1);
      if (k == 5) chk("b2b ready on last pair", in_ready, 1);
      cyc();
      if (k == 5) in_valid = 1'b0;
    end
    chk("b2b idle after", busy, 0);

`ifdef DDR_SERIALISER_UNDERFLOW_EN
    // Non-last word with no follow-up raises underflow after its last pair.
    in_valid = 1'b1;
    in_data  = W'($urandom);
    in_last  = 1'b0;
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("uf before last edge", underflow, 0);
    cyc();
    chk("uf set", underflow, 1);
    underflow_clr = 1'b1;
    cyc();
    underflow_clr = 1'b0;
    chk("uf cleared", underflow, 0);
    // Last word: no underflow.
    in_valid = 1'b1;
    in_data  = W'($urandom);
    in_last  = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (6) cyc();
    chk("uf stays clear with last", underflow, 0);
    // Set and clear on the same edge: set wins.
    in_valid = 1'b1;
    in_data  = W'($urandom);
    in_last  = 1'b0;
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    underflow_clr = 1'b1;
    cyc();
    chk("uf set beats clear", underflow, 1);
    cyc();
    underflow_clr = 1'b0;
    chk("uf cleared again", underflow, 0);
`endif

    // Reset in the middle of a word.
    in_valid = 1'b1;
    in_data  = W'($urandom);
    in_last  = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst d_rise", d_rise, IDLE);
    chk("midrst d_fall", d_fall, IDLE);
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst e", e, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    in_valid = 1'b1;
    in_data  = w2;
    cyc();
    in_valid = 1'b0;
    chk("post-reset first pair", {d_rise, d_fall}, 2'b11);
    repeat (5) cyc();
    chk("post-reset idle", busy, 0);

    // Randomised streaming with in_valid toggling.
    ref_words.delete();
    dut_bits.delete();
    busy_cycles = 0;
    words       = 0;
    cycles      = 0;
    in_valid    = 1'b0;
    while (words < 1000 && cycles < 20000) begin
      if (!in_valid || m_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
      end
`ifdef DDR_SERIALISER_UNDERFLOW_EN
      underflow_clr = ($urandom_range(0, 7) == 0);
`endif
      cyc();
      cycles++;
      if (m_acc) words++;
    end
    in_valid = 1'b0;
`ifdef DDR_SERIALISER_UNDERFLOW_EN
    underflow_clr = 1'b0;
`endif
    chk("random words accepted", words, 1000);
    repeat (7) cyc();
    chk("random bit count", dut_bits.size(), ref_words.size() * W);
    chk("random cycles per word", busy_cycles, ref_words.size() * (W / 2));
    for (int i = 0; i < ref_words.size(); i++) begin
      logic [W-1:0] got;
      got = '0;
      for (int b = 0; b < W; b++) begin
        if (i * W + b < dut_bits.size()) got[W-1-b] = dut_bits[i*W+b];
      end
      chk("random word", got, ref_words[i]);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
